// File: rtl/liteic_rr_arbiter.sv
// Round-robin arbiter with a locked grant, released by done_i or by a hold timeout.
// Rotation uses an MSB-first mask: after granting k, only indices below k are preferred next.
module liteic_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 256
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [N_REQ-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             to_q, to_d;

    logic [N_REQ-1:0] cand;
    logic [ID_W-1:0]  win;
    logic             timeout_hit;
    logic             release_w;
    logic             grant_new;

    function automatic logic [ID_W-1:0] msb_index(input logic [N_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        cand        = req_i & mask_q;
        win         = (|cand) ? msb_index(cand) : msb_index(req_i);
        // done_i wins over the timeout, so the timeout only fires without done_i
        timeout_hit = (TIMEOUT != 0) && (state_q == GRANT) && !done_i && (cnt_q == CNT_LAST);
        release_w   = (state_q == GRANT) && (done_i || timeout_hit);
        grant_new   = (|req_i) && ((state_q == IDLE) || release_w);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        to_d    = timeout_hit;
        if (grant_new) begin
            state_d = GRANT;
            gnt_d   = N_REQ'(1) << win;
            id_d    = win;
            mask_d  = (N_REQ'(1) << win) - N_REQ'(1);
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (release_w) begin
            state_d = IDLE;
            gnt_d   = '0;
            id_d    = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else if ((state_q == GRANT) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            mask_q  <= '1;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            to_q    <= to_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = id_q;
    assign busy_o    = busy_q;
    assign timeout_o = to_q;

endmodule

// File: tb/tb_liteic_rr_arbiter.sv
// Directed bench for liteic_rr_arbiter (N_REQ=4, TIMEOUT=8) with hand-computed expectations.
module tb_liteic_rr_arbiter;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tout;

    int tests;
    int fails;

    liteic_rr_arbiter #(
        .N_REQ  (4),
        .ID_W   (2),
        .TIMEOUT(8)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .req_i    (req),
        .done_i   (done),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .busy_o   (busy),
        .timeout_o(tout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                             input logic eb, input logic et);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".tout"}, 32'(tout), 32'(et));
    endtask

    initial begin
        logic [1:0] order [5];
        tests = 0;
        fails = 0;
        rstn  = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        order = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

        // Reset: held low across clock edges with a request present
        req = 4'b1111;
        step();
        step();
        chk_state("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        req  = 4'b0000;
        rstn = 1'b1;
        step();
        chk_state("idle_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Mask rotation: 0101 -> 2, then 0, then 2
        req = 4'b0101;
        step();
        chk_state("r029_first", 4'b0100, 2'd2, 1'b1, 1'b0);
        done = 1'b1;
        step();
        chk_state("r029_second", 4'b0001, 2'd0, 1'b1, 1'b0);
        step();
        chk_state("r029_third", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        done = 1'b0;
        chk_state("r029_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done_i in IDLE is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        chk_state("done_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Fresh reset so the rotation starts from the top
        rstn = 1'b0;
        #2;
        rstn = 1'b1;

        // All requesting, done_i every 3 cycles: 3,2,1,0,3 with no bubble
        req = 4'b1111;
        step();
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 3; c++) begin
                chk_state($sformatf("r030_g%0d_c%0d", g, c), 4'(1) << order[g], order[g], 1'b1, 1'b0);
                if (c == 2 && g < 4) done = 1'b1;
                if (g < 4 || c < 2) step();
                done = 1'b0;
            end
        end
        req  = 4'b0000;
        done = 1'b1;
        step();
        done = 1'b0;
        chk_state("r030_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Locked grant: requester 1 drops its request, grant persists
        req = 4'b0010;
        step();
        chk_state("r031_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("r031_hold%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk_state("r031_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Timeout after 8 grant cycles, regranted to 3 while req_i[3] stays high
        req = 4'b1000;
        step();
        for (int i = 1; i <= 8; i++) begin
            chk_state($sformatf("r032_cyc%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
            step();
        end
        chk_state("r032_regrant", 4'b1000, 2'd3, 1'b1, 1'b1);
        step();
        chk_state("r032_pulse_end", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        for (int i = 0; i < 7; i++) step();
        chk_state("r032_to_idle", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk_state("r032_idle_quiet", 4'b0000, 2'd0, 1'b0, 1'b0);

        // done_i coinciding with the timeout cycle: release without timeout_o
        req = 4'b1000;
        step();
        for (int i = 0; i < 7; i++) step();
        chk_state("r034_last_cycle", 4'b1000, 2'd3, 1'b1, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        step();
        done = 1'b0;
        chk_state("r034_release", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-grant, then first arbitration picks the top requester
        req = 4'b1000;
        step();
        chk_state("r033_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        chk_state("r033_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        #3;
        rstn = 1'b1;
        req  = 4'b0011;
        step();
        chk_state("r033_after", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/liteic_rr_arbiter.md
LITEIC_RR_ARBITER -- requirements
Module: liteic_rr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesters (2..32).
REQ-002 SHALL have parameter ID_W, default $clog2(N_REQ), meaning the width of the binary grant index.
REQ-003 SHALL have parameter TIMEOUT, default 256, meaning the maximum number of cycles a grant is held without done_i; 0 disables the timeout.
REQ-004 SHALL have port clk_i  input  1  system clock, rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port req_i  input  N_REQ  per-requester level request.
REQ-007 SHALL have port done_i  input  1  single-cycle pulse meaning the granted transaction is complete.
REQ-008 SHALL have port gnt_o  output  N_REQ  one-hot grant, or all zeros when idle.
REQ-009 SHALL have port gnt_id_o  output  ID_W  binary index of the granted requester, 0 when idle.
REQ-010 SHALL have port busy_o  output  1  high while a grant is held.
REQ-011 SHALL have port timeout_o  output  1  one-cycle pulse when a grant is force-released.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and GRANT, with all outputs driven from registers.
REQ-013 In IDLE, when req_i is nonzero at a rising edge, SHALL enter GRANT and assert gnt_o, gnt_id_o and busy_o from the next cycle (1-cycle latency).
REQ-014 Selection SHALL use the MSB-first priority rule: cand = req_i & mask_q; if cand is nonzero, the winner is the highest set bit of cand; otherwise the winner is the highest set bit of req_i.
REQ-015 mask_q SHALL reset to all ones; on granting index k, mask_q SHALL load ones in bits [k-1:0] and zeros elsewhere, so that k=0 loads all zeros.
REQ-016 gnt_o SHALL be exactly one-hot in GRANT, and gnt_id_o SHALL equal the index of its set bit.
REQ-017 In GRANT, the grant SHALL be locked; deasserting the granted requester's req_i SHALL NOT release it, and only done_i or the timeout SHALL release it.
REQ-018 On done_i in GRANT with req_i nonzero, SHALL arbitrate in the same edge using the updated mask rule and present the new grant on the next cycle with no idle bubble.
REQ-019 On done_i in GRANT with req_i zero, SHALL return to IDLE, with gnt_o=0, gnt_id_o=0 and busy_o=0 on the next cycle.
REQ-020 done_i in IDLE SHALL be ignored.
REQ-021 The hold counter SHALL reset to 0 on each new grant, increment each GRANT cycle without done_i, and saturate at TIMEOUT.
REQ-022 When TIMEOUT is nonzero and the counter reaches TIMEOUT-1 without done_i, SHALL release the grant exactly as done_i would, and pulse timeout_o for one cycle coincident with the next grant state.
REQ-023 If done_i and the timeout condition occur in the same cycle, done_i SHALL take precedence and timeout_o SHALL stay low.
REQ-024 A requester that is never granted SHALL wait at most N_REQ-1 other grants while its req_i is held high (starvation-free).
REQ-025 Requests whose index is at or above N_REQ SHALL NOT exist; ID_W SHALL be at least 1 for N_REQ=2.

Reset
REQ-026 Asserting rstn_i low SHALL immediately (asynchronously) force the state to IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, counter=0 and mask_q to all ones.
REQ-027 Reset asserted during GRANT SHALL drop the grant without waiting for done_i.
REQ-028 Deassertion of rstn_i SHALL take effect at the next rising clk_i, and the first arbitration SHALL pick the highest requesting index.

Verification
REQ-029 With N_REQ=4 after reset, req_i=4'b0101 -> gnt_o=4'b0100 and gnt_id_o=2 one cycle later; then done_i -> gnt_o=4'b0001; then done_i -> gnt_o=4'b0100.
REQ-030 With req_i=4'b1111 held and done_i pulsed every 3 cycles -> grant order 3,2,1,0,3 with no idle cycle between grants and busy_o high throughout.
REQ-031 With requester 1 granted, dropping req_i[1] while done_i stays low -> gnt_o stays 4'b0010; then done_i with req_i=0 -> gnt_o=0 and busy_o=0 next cycle.
REQ-032 With TIMEOUT=8 and a single request 4'b1000 with no done_i -> the grant is released after 8 GRANT cycles with one timeout_o pulse, and the grant is reissued to 3 if req_i[3] is still high.
REQ-033 With rstn_i pulsed low mid-grant -> gnt_o=0 within the same cycle without a clock edge, and after release req_i=4'b0011 -> gnt_id_o=1.
REQ-034 With done_i and the timeout coinciding at cycle TIMEOUT-1 -> release occurs and timeout_o stays 0.
